// File: rtl/fifo_flags_buf.sv
// Circular-queue FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow flags and an optional registered read stage.
module fifo_flags_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_ok, wr_ok;

    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A pop on a full FIFO frees the slot the simultaneous write lands in.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        ovf_d   = clr_err ? 1'b0 : ovf_q;
        udf_d   = clr_err ? 1'b0 : udf_q;

        if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
        if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // New errors win over a same-edge clear.
        if (wr & ~wr_ok) ovf_d = 1'b1;
        if (rd & empty)  udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr_q] <= w_data;
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
        logic                  r_valid_q, r_valid_d;

        always_comb begin
            r_data_d  = r_data_q;
            r_valid_d = rd_ok;
            if (rd_ok) r_data_d = mem[r_ptr_q];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end else begin : g_comb
        assign r_data  = mem[r_ptr_q];
        assign r_valid = 1'b0;
    end

endmodule

// File: tb/tb_fifo_flags_buf.sv
// Directed bench: a combinational-read FIFO and a registered-read FIFO
// driven in lockstep with identical stimulus.
module tb_fifo_flags_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr, rd, clr_err;
    logic [7:0] w_data;

    logic [7:0] r_data0, r_data1;
    logic       r_valid0, r_valid1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] count0, count1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp2 [8];
    logic [7:0] exp4 [8];

    always #5 clk = ~clk;

    fifo_flags_buf #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .clr_err(clr_err), .r_data(r_data0), .r_valid(r_valid0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    fifo_flags_buf #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .clr_err(clr_err), .r_data(r_data1), .r_valid(r_valid1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies one operation across the next posedge.
    task automatic op(input logic w, input logic r, input logic [7:0] d,
                      input logic c);
        wr = w; rd = r; w_data = d; clr_err = c;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        exp2 = '{8'd5, 8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6};
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_udf", udf0, 0);
        chk("rst_rvalid0", r_valid0, 0);
        chk("rst_rvalid1", r_valid1, 0);
        chk("rst_rdata1", r_data1, 0);

        // 1: six writes
        op(1, 0, 8'd5, 0);
        chk("t1_count1", count0, 1);
        chk("t1_ae1", ae0, 1);
        chk("t1_head", r_data0, 5);
        op(1, 0, 8'd8, 0);
        chk("t1_ae2", ae0, 0);
        op(1, 0, 8'd12, 0);
        op(1, 0, 8'd2, 0);
        op(1, 0, 8'd9, 0);
        chk("t1_af5", af0, 0);
        op(1, 0, 8'd14, 0);
        chk("t1_count6", count0, 6);
        chk("t1_af6", af0, 1);

        // 2: fill, overflow, drain
        op(1, 0, 8'd13, 0);
        chk("t2_count7", count0, 7);
        chk("t2_full7", full0, 0);
        op(1, 0, 8'd6, 0);
        chk("t2_full", full0, 1);
        chk("t2_count8", count0, 8);
        chk("t2_ovf_pre", ovf0, 0);
        op(1, 0, 8'd7, 0);
        chk("t2_ovf", ovf0, 1);
        chk("t2_ovf1", ovf1, 1);
        chk("t2_count_drop", count0, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_rd0_%0d", i), r_data0, exp2[i]);
            op(0, 1, 8'd0, 0);
            chk($sformatf("t6_rd1_%0d", i), r_data1, exp2[i]);
            chk($sformatf("t6_rv_%0d", i), r_valid1, 1);
        end
        chk("t2_empty", empty0, 1);
        chk("t2_count0", count0, 0);
        chk("t2_udf", udf0, 0);
        op(0, 0, 8'd0, 0);
        chk("t6_rv_idle", r_valid1, 0);
        chk("t6_rd_hold", r_data1, 6);
        chk("t2_ovf_sticky", ovf0, 1);

        // 3: wr+rd on empty
        op(1, 1, 8'd17, 0);
        chk("t3_count", count0, 1);
        chk("t3_udf", udf0, 1);
        chk("t3_rv", r_valid1, 0);
        chk("t3_head", r_data0, 17);
        op(0, 1, 8'd0, 0);
        chk("t3_rd1", r_data1, 17);
        chk("t3_empty", empty0, 1);
        op(0, 0, 8'd0, 1);
        chk("t3_clr_ovf", ovf0, 0);
        chk("t3_clr_udf", udf0, 0);
        op(0, 1, 8'd0, 1);
        chk("t3_set_beats_clr", udf0, 1);
        chk("t3_empty_rd_hold", r_data1, 17);
        op(0, 0, 8'd0, 1);
        chk("t3_clr2", udf0, 0);

        // 4: wr+rd on full, pointers now at slot 1 so this wraps
        for (int i = 0; i < 8; i++) begin
            exp4[i] = 8'h20 + 8'(i);
            op(1, 0, exp4[i], 0);
        end
        chk("t4_full", full0, 1);
        op(1, 1, 8'd11, 0);
        chk("t4_count", count0, 8);
        chk("t4_ovf", ovf0, 0);
        chk("t4_rd1_first", r_data1, 8'h20);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = (i == 7) ? 8'd11 : exp4[i + 1];
            chk($sformatf("t4_rd0_%0d", i), r_data0, e);
            op(0, 1, 8'd0, 0);
            chk($sformatf("t4_rd1_%0d", i), r_data1, e);
        end
        chk("t4_empty", empty0, 1);

        // 5: async reset mid-burst
        op(1, 0, 8'd1, 0);
        op(1, 0, 8'd2, 0);
        op(1, 0, 8'd3, 0);
        chk("t5_count3", count0, 3);
        #2 reset = 1'b1;
        #1;
        chk("t5_count", count0, 0);
        chk("t5_empty", empty0, 1);
        chk("t5_ae", ae0, 1);
        chk("t5_full", full0, 0);
        chk("t5_rdata1", r_data1, 0);
        chk("t5_count1", count1, 0);
        @(negedge clk);
        reset = 1'b0;
        op(1, 0, 8'd4, 0);
        chk("t5_head", r_data0, 4);
        op(0, 1, 8'd0, 0);
        chk("t5_rd1", r_data1, 4);
        chk("t5_rv", r_valid1, 1);
        chk("t5_empty_end", empty0, 1);
        chk("t5_udf", udf0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
